// File: rtl/epp_pkg.sv
// Shared types and constants for the EPP slave controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package epp_pkg;

  localparam int EPP_DW = 8;
  localparam int EPP_AW = 8;

  // Read data returned to the host when the register bus never acknowledges.
  localparam logic [EPP_DW-1:0] TMO_DATA = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADR   = 3'd1,
    ST_DREQ  = 3'd2,
    ST_DWAIT = 3'd3,
    ST_HOLD  = 3'd4
  } epp_state_t;

  // Address post-increment; wraps from all-ones to zero.
  function automatic logic [EPP_AW-1:0] next_addr(input logic [EPP_AW-1:0] a);
    return a + {{(EPP_AW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/epp_bus_ctrl_if.sv
// EPP pin bundle plus internal register-bus signals of the EPP controller.
// Latency: n/a (wires only).
// Backpressure: host waits on EppWait; bus side completes on bus_ack or timeout.
interface epp_bus_ctrl_if;
  import epp_pkg::*;

  // Host (EPP pin) side
  logic              EppAstb;
  logic              EppDstb;
  logic              EppWr;
  logic              EppWait;
  logic [EPP_DW-1:0] EppDB_i;
  logic [EPP_DW-1:0] EppDB_o;
  logic              EppDB_oe;

  // Register bus side
  logic [EPP_AW-1:0] bus_addr;
  logic [EPP_DW-1:0] bus_wdata;
  logic              bus_we;
  logic              bus_re;
  logic [EPP_DW-1:0] bus_rdata;
  logic              bus_ack;
  logic              bus_tmo;

  // Controller view
  modport master (
    input  EppAstb, EppDstb, EppWr, EppDB_i, bus_rdata, bus_ack,
    output EppWait, EppDB_o, EppDB_oe, bus_addr, bus_wdata, bus_we, bus_re, bus_tmo
  );

  // Environment view: host pins and register responder
  modport slave (
    output EppAstb, EppDstb, EppWr, EppDB_i, bus_rdata, bus_ack,
    input  EppWait, EppDB_o, EppDB_oe, bus_addr, bus_wdata, bus_we, bus_re, bus_tmo
  );

endinterface

// File: rtl/epp_sync.sv
// Multi-flop synchronizer for one asynchronous EPP control line.
// Latency: SYNC_STG clocks from pin to q_o.
// Backpressure: none; resets to 1 (the inactive level of the EPP strobes).
module epp_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STG-1:0] chain_q;

  // Shift the raw pin level through the flop chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '1;
    end else begin
      chain_q <= {chain_q[SYNC_STG-2:0], d_i};
    end
  end

  assign q_o = chain_q[SYNC_STG-1];

endmodule

// File: rtl/epp_bus_ctrl.sv
// Adept2 EPP slave: decodes host address/data strobes onto an 8-bit req/ack register bus.
// Latency: EppWait rises SYNC_STG+2 clocks after an address strobe falls (data: plus ack wait).
// Backpressure: host held via EppWait; bus request held until bus_ack or TIMEOUT cycles.
// Optional build macro EPP_AUTOINC_EN: bus_addr post-increments after each data cycle.
module epp_bus_ctrl
  import epp_pkg::*;
#(
  parameter int TIMEOUT  = 16,
  parameter int SYNC_STG = 2
) (
  input  logic           clk,
  input  logic           reset,
  epp_bus_ctrl_if.master bif
);

  localparam logic [7:0] TMO_CNT = 8'(TIMEOUT);

  // Synchronized host controls
  logic astb_s;
  logic dstb_s;
  logic wr_s;

  epp_sync #(.SYNC_STG(SYNC_STG)) u_sync_astb (
    .clk   (clk),
    .reset (reset),
    .d_i   (bif.EppAstb),
    .q_o   (astb_s)
  );

  epp_sync #(.SYNC_STG(SYNC_STG)) u_sync_dstb (
    .clk   (clk),
    .reset (reset),
    .d_i   (bif.EppDstb),
    .q_o   (dstb_s)
  );

  epp_sync #(.SYNC_STG(SYNC_STG)) u_sync_wr (
    .clk   (clk),
    .reset (reset),
    .d_i   (bif.EppWr),
    .q_o   (wr_s)
  );

  epp_state_t        state_q;
  logic              wr_q;        // direction latched at decode
  logic              addr_cyc_q;  // 1: current cycle is an address cycle (Astb is the active strobe)
  logic [EPP_DW-1:0] db_q;        // pin data sampled at decode
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;
  logic              wait_q;
  logic              oe_q;
  logic [EPP_DW-1:0] dbo_q;
  logic [EPP_AW-1:0] addr_q;
  logic [EPP_DW-1:0] wdata_q;
  logic              we_q;
  logic              re_q;
  logic              tmo_q;
  logic              strobe_rel;

  assign cnt_d      = cnt_q + 8'd1;
  // Release is judged on the strobe that started the cycle only.
  assign strobe_rel = addr_cyc_q ? astb_s : dstb_s;

  // Cycle sequencer: decode, bus request, ack/timeout wait and host handshake hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_q       <= 1'b0;
      addr_cyc_q <= 1'b0;
      db_q       <= '0;
      cnt_q      <= '0;
      wait_q     <= 1'b0;
      oe_q       <= 1'b0;
      dbo_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          wr_q <= wr_s;
          db_q <= bif.EppDB_i;
          if (!astb_s) begin
            addr_cyc_q <= 1'b1;
            state_q    <= ST_ADR;
          end else if (!dstb_s) begin
            addr_cyc_q <= 1'b0;
            state_q    <= ST_DREQ;
          end
        end

        ST_ADR: begin
          if (!wr_q) begin
            addr_q <= db_q;
          end else begin
            dbo_q <= addr_q;
            oe_q  <= 1'b1;
          end
          wait_q  <= 1'b1;
          state_q <= ST_HOLD;
        end

        ST_DREQ: begin
          if (!wr_q) begin
            wdata_q <= db_q;
            we_q    <= 1'b1;
          end else begin
            re_q <= 1'b1;
          end
          cnt_q   <= '0;
          state_q <= ST_DWAIT;
        end

        ST_DWAIT: begin
          // An ack landing on the timeout cycle still completes normally.
          if (bif.bus_ack) begin
            we_q <= 1'b0;
            re_q <= 1'b0;
            if (wr_q) begin
              dbo_q <= bif.bus_rdata;
              oe_q  <= 1'b1;
            end
            wait_q  <= 1'b1;
            state_q <= ST_HOLD;
          end else if (cnt_d == TMO_CNT) begin
            we_q  <= 1'b0;
            re_q  <= 1'b0;
            tmo_q <= 1'b1;
            if (wr_q) begin
              dbo_q <= TMO_DATA;
              oe_q  <= 1'b1;
            end
            wait_q  <= 1'b1;
            state_q <= ST_HOLD;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        ST_HOLD: begin
          if (strobe_rel) begin
            wait_q  <= 1'b0;
            oe_q    <= 1'b0;
            state_q <= ST_IDLE;
`ifdef EPP_AUTOINC_EN
            if (!addr_cyc_q) begin
              addr_q <= next_addr(addr_q);
            end
`else
`endif
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bif.EppWait   = wait_q;
  assign bif.EppDB_o   = dbo_q;
  assign bif.EppDB_oe  = oe_q;
  assign bif.bus_addr  = addr_q;
  assign bif.bus_wdata = wdata_q;
  assign bif.bus_we    = we_q;
  assign bif.bus_re    = re_q;
  assign bif.bus_tmo   = tmo_q;

endmodule

// File: tb/tb_epp_bus_ctrl.sv
// Randomized EPP host + register responder checked against a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_epp_bus_ctrl;

  localparam int TIMEOUT  = 16;
  localparam int SYNC_STG = 2;
  localparam int NEVER    = 1000;

`ifdef EPP_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  epp_bus_ctrl_if bif();

  epp_bus_ctrl #(.TIMEOUT(TIMEOUT), .SYNC_STG(SYNC_STG)) dut (
    .clk   (clk),
    .reset (reset),
    .bif   (bif)
  );

  int errors = 0;
  int checks = 0;

  // Model state
  logic [7:0] model_addr = 8'h00;
  bit         exp_wr     = 1'b0;
  logic [7:0] exp_wdata  = 8'h00;
  bit         mon_en     = 1'b1;
  int         ack_delay  = NEVER;
  logic [7:0] rsp_data   = 8'h00;
  logic [7:0] last_o;
  bit         last_tmo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register responder: acks ack_delay samples after the request first appears.
  initial begin
    int  cnt;
    bit  armed;
    armed = 1'b0;
    cnt   = 0;
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (bif.bus_we || bif.bus_re) begin
        if (!armed) begin
          armed = 1'b1;
          cnt   = 0;
        end
        if (cnt == ack_delay) begin
          bif.bus_ack   = 1'b1;
          bif.bus_rdata = rsp_data;
        end else begin
          bif.bus_ack   = 1'b0;
          bif.bus_rdata = 8'($urandom);
        end
        cnt++;
      end else begin
        armed         = 1'b0;
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = 8'($urandom);
      end
    end
  end

  // Per-cycle bus request checks against the model.
  always @(negedge clk) begin
    if (mon_en && !reset && (bif.bus_we || bif.bus_re)) begin
      check("req_exclusive", {31'b0, bif.bus_we & bif.bus_re}, 32'd0);
      check("req_direction", {31'b0, bif.bus_re}, {31'b0, exp_wr});
      check("req_addr", {24'b0, bif.bus_addr}, {24'b0, model_addr});
      check("req_wait_low", {31'b0, bif.EppWait}, 32'd0);
      if (bif.bus_we) check("req_wdata", {24'b0, bif.bus_wdata}, {24'b0, exp_wdata});
    end
  end

  // Strobe already low: wait for EppWait, check hold state, release, check fall.
  task automatic finish_cycle(input bit is_addr, input bit wr, input logic [7:0] din,
                              input int delay, input logic [7:0] rsp);
    int         n;
    int         exp_lat;
    bit         exp_tmo;
    logic [7:0] exp_o;
    exp_tmo = !is_addr && (delay >= TIMEOUT);
    exp_lat = is_addr ? SYNC_STG + 2 : (exp_tmo ? SYNC_STG + 2 + TIMEOUT : SYNC_STG + 3 + delay);
    n = 0;
    while (n < 200 && !bif.EppWait) begin
      @(posedge clk); #1;
      n++;
      if (n == 2 && $urandom_range(0, 1) == 1) bif.EppWr = ~wr;
    end
    check("wait_rise_latency", n, exp_lat);
    check("tmo_pulse", {31'b0, bif.bus_tmo}, {31'b0, exp_tmo});
    last_tmo = bif.bus_tmo;
    last_o   = bif.EppDB_o;
    check("req_off_in_hold", {31'b0, bif.bus_we | bif.bus_re}, 32'd0);
    if (is_addr && !wr) model_addr = din;
    if (wr) begin
      exp_o = is_addr ? model_addr : (exp_tmo ? 8'hFF : rsp);
      check("oe_read", {31'b0, bif.EppDB_oe}, 32'd1);
      check("dbo_read", {24'b0, bif.EppDB_o}, {24'b0, exp_o});
    end else begin
      check("oe_write", {31'b0, bif.EppDB_oe}, 32'd0);
    end
    check("addr_in_hold", {24'b0, bif.bus_addr}, {24'b0, model_addr});
    repeat ($urandom_range(1, 3)) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 1) == 1) bif.EppWr = ~bif.EppWr;
      check("wait_held", {31'b0, bif.EppWait}, 32'd1);
      check("tmo_one_cycle", {31'b0, bif.bus_tmo}, 32'd0);
    end
    bif.EppAstb = 1'b1;
    bif.EppDstb = 1'b1;
    n = 0;
    while (n < 50 && bif.EppWait) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_fall_latency", n, SYNC_STG + 1);
    check("oe_released", {31'b0, bif.EppDB_oe}, 32'd0);
    if (AUTOINC && !is_addr) model_addr = model_addr + 8'd1;
    check("addr_after", {24'b0, bif.bus_addr}, {24'b0, model_addr});
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic epp_cycle(input bit is_addr, input bit wr, input bit both,
                           input logic [7:0] din, input int delay, input logic [7:0] rsp);
    ack_delay   = delay;
    rsp_data    = rsp;
    exp_wr      = wr;
    exp_wdata   = din;
    bif.EppWr   = wr;
    bif.EppDB_i = din;
    if (is_addr) begin
      bif.EppAstb = 1'b0;
      if (both) bif.EppDstb = 1'b0;
    end else begin
      bif.EppDstb = 1'b0;
    end
    finish_cycle(is_addr, wr, din, delay, rsp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t6 [3];
    int         n;
    bit         is_addr;
    int         dly;
`ifdef EPP_AUTOINC_EN
    t6[0] = 8'hFE; t6[1] = 8'hFF; t6[2] = 8'h00;
`else
    t6[0] = 8'hFE; t6[1] = 8'hFE; t6[2] = 8'hFE;
`endif
    reset       = 1'b1;
    bif.EppAstb = 1'b1;
    bif.EppDstb = 1'b1;
    bif.EppWr   = 1'b1;
    bif.EppDB_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wait", {31'b0, bif.EppWait}, 32'd0);
    check("rst_oe", {31'b0, bif.EppDB_oe}, 32'd0);
    check("rst_dbo", {24'b0, bif.EppDB_o}, 32'd0);
    check("rst_we_re", {30'b0, bif.bus_we, bif.bus_re}, 32'd0);
    check("rst_addr", {24'b0, bif.bus_addr}, 32'd0);
    check("rst_wdata", {24'b0, bif.bus_wdata}, 32'd0);
    check("rst_tmo", {31'b0, bif.bus_tmo}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: address write
    epp_cycle(1'b1, 1'b0, 1'b0, 8'h01, 0, 8'h00);
    check("t1_addr", {24'b0, bif.bus_addr}, 32'h01);
    // 2: data write, ack after 2
    epp_cycle(1'b0, 1'b0, 1'b0, 8'hAA, 2, 8'h00);
    check("t2_wdata", {24'b0, bif.bus_wdata}, 32'hAA);
    // 3: data read acked with 5C after 3
    epp_cycle(1'b0, 1'b1, 1'b0, 8'h00, 3, 8'h5C);
    check("t3_dbo", {24'b0, last_o}, 32'h5C);
    // 4: data read, no ack
    epp_cycle(1'b0, 1'b1, 1'b0, 8'h00, NEVER, 8'h00);
    check("t4_tmo", {31'b0, last_tmo}, 32'd1);
    check("t4_dbo", {24'b0, last_o}, 32'hFF);
    // Ack coincident with timeout wins; one cycle later times out
    epp_cycle(1'b0, 1'b1, 1'b0, 8'h00, TIMEOUT - 1, 8'h3A);
    check("ack_on_tmo_dbo", {24'b0, last_o}, 32'h3A);
    epp_cycle(1'b0, 1'b0, 1'b0, 8'h77, TIMEOUT, 8'h00);
    check("late_ack_tmo", {31'b0, last_tmo}, 32'd1);
    // Both strobes low: address cycle wins (address read)
    epp_cycle(1'b1, 1'b1, 1'b1, 8'h00, 0, 8'h00);

    // 5: reset during DWAIT
    epp_cycle(1'b1, 1'b0, 1'b0, 8'h37, 0, 8'h00);
    ack_delay   = NEVER;
    exp_wr      = 1'b1;
    bif.EppWr   = 1'b1;
    bif.EppDstb = 1'b0;
    n = 0;
    while (n < 40 && !bif.bus_re) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_re_up", {31'b0, bif.bus_re}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk); #1;
    reset  = 1'b0;
    check("t5_wait", {31'b0, bif.EppWait}, 32'd0);
    check("t5_oe", {31'b0, bif.EppDB_oe}, 32'd0);
    check("t5_dbo", {24'b0, bif.EppDB_o}, 32'd0);
    check("t5_re", {31'b0, bif.bus_re}, 32'd0);
    check("t5_we", {31'b0, bif.bus_we}, 32'd0);
    check("t5_addr", {24'b0, bif.bus_addr}, 32'd0);
    check("t5_wdata", {24'b0, bif.bus_wdata}, 32'd0);
    check("t5_tmo", {31'b0, bif.bus_tmo}, 32'd0);
    model_addr = 8'h00;
    mon_en     = 1'b1;
    finish_cycle(1'b0, 1'b1, 8'h00, NEVER, 8'h00);

    // 6: address FE then three reads
    epp_cycle(1'b1, 1'b0, 1'b0, 8'hFE, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check("t6_addr", {24'b0, bif.bus_addr}, {24'b0, t6[i]});
      epp_cycle(1'b0, 1'b1, 1'b0, 8'h00, 1, 8'(8'h10 + i));
    end

    // Randomized traffic
    for (int k = 0; k < 120; k++) begin
      is_addr = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 9) < 7) dly = $urandom_range(0, 5);
      else                          dly = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
      epp_cycle(is_addr, 1'($urandom_range(0, 1)),
                is_addr && ($urandom_range(0, 3) == 0),
                8'($urandom), dly, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
